// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO data width, write-arbiter state encoding and index helper
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, BURST, STALL} arb_state_t;
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1) % n;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: rotating-priority first-one finder starting at rr_ptr
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      index,
  output logic               valid
);
  // scan from farthest to nearest so the closest requester at or after rr_ptr wins
  always_comb begin
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) index = IW'((int'(rr_ptr) + k) % NUM_REQ);
  end
  assign valid = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int BURST_LEN = 4,
  parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int BW = $clog2(BURST_LEN) + 1
) (
  input  logic                          clk_wr,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [IW-1:0]                 owner,
  output logic                          busy,
  output logic [15:0]                   stall_cnt
);
  arb_state_t     state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  pick;
  logic           pick_valid;
  logic [BW-1:0]  beat_cnt;
  logic [IW-1:0]  owner_nxt;
  logic           last_beat;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req(req),
    .rr_ptr(rr_ptr),
    .index(pick),
    .valid(pick_valid)
  );

  assign owner_nxt = IW'(wrap_inc(int'(owner), NUM_REQ));
  assign last_beat = beat_cnt == BW'(BURST_LEN - 1);
  assign gnt       = (state == BURST && !full) ? NUM_REQ'(1) << owner : '0;
  assign wr_en     = req[owner] && gnt[owner];
  assign data_in   = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
  assign busy      = state != IDLE;

  // a dropped request ends the burst from either BURST or STALL, even while full
  always_ff @(posedge clk_wr or posedge rst)
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else
      case (state)
        IDLE:
          if (pick_valid) begin
            owner    <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        BURST:
          if (!req[owner]) begin
            state  <= IDLE;
            rr_ptr <= owner_nxt;
          end else if (full) state <= STALL;
          else begin
            beat_cnt <= beat_cnt + BW'(1);
            if (last_beat) begin
              state  <= IDLE;
              rr_ptr <= owner_nxt;
            end
          end
        STALL: begin
          if (!(&stall_cnt)) stall_cnt <= stall_cnt + 16'd1;
          if (!req[owner]) begin
            state  <= IDLE;
            rr_ptr <= owner_nxt;
          end else if (!full) state <= BURST;
        end
        default: state <= IDLE;
      endcase
endmodule
